// File: rtl/button_conditioner_if.sv
// Signal bundle between the raw push-buttons and the game controller.
// Strobes are one-cycle registered pulses; there is no backpressure.
interface button_conditioner_if;
  logic       btn_drop_in;
  logic       btn_right_in;
  logic       btn_left_in;
  logic       drop_pulse;
  logic       right_pulse;
  logic       left_pulse;
  logic [2:0] btn_state;

  modport master (
    output btn_drop_in, btn_right_in, btn_left_in,
    input  drop_pulse, right_pulse, left_pulse, btn_state
  );

  modport slave (
    input  btn_drop_in, btn_right_in, btn_left_in,
    output drop_pulse, right_pulse, left_pulse, btn_state
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects three push-buttons into command strobes.
// Optional auto-repeat for left/right is enabled by defining AUTO_REPEAT_EN.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 10000000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input logic            clk,
  input logic            rst,
  button_conditioner_if.slave bus
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'h000F_FFFF) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range");
  end
  if (REPEAT_DELAY < 2 || REPEAT_DELAY > 32'h00FF_FFFF) begin : g_bad_delay
    $error("REPEAT_DELAY out of range");
  end
  if (REPEAT_PERIOD < 2 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_period
    $error("REPEAT_PERIOD out of range");
  end

  localparam logic [19:0] DEB_LIM = 20'(DEBOUNCE_CYCLES);

  // Bit order everywhere is {left, right, drop}.
  logic [2:0]  raw;
  logic [2:0]  sync_a;
  logic [2:0]  sync_b;
  logic [2:0]  deb;
  logic [2:0]  deb_q;
  logic [2:0]  rise;
  logic [19:0] cnt [3];
  logic        conflict;
  logic        rep_left;
  logic        rep_right;
  logic        drop_q;
  logic        right_q;
  logic        left_q;

  assign raw = {bus.btn_left_in, bus.btn_right_in, bus.btn_drop_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // A level is accepted only after it has differed from the debounced
  // level for DEBOUNCE_CYCLES consecutive cycles plus the accepting cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync_b[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_LIM) begin
          deb[i] <= sync_b[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 20'd1;
        end
      end
    end
  end

  assign rise     = deb & ~deb_q;
  assign conflict = deb[2] & deb[1];

`ifdef AUTO_REPEAT_EN
  localparam logic [23:0] DELAY_LIM  = 24'(REPEAT_DELAY);
  localparam logic [23:0] PERIOD_LIM = 24'(REPEAT_PERIOD);

  logic [23:0] rep_tmr;
  logic        rep_first;
  logic        single;
  logic        rep_fire;

  // Timer is 0 when parked; it only runs after an initial left/right strobe
  // and parks again on release, conflict or reset.
  assign single   = deb[2] ^ deb[1];
  assign rep_fire = single && (rep_tmr != 24'd0) &&
                    (rep_tmr == (rep_first ? DELAY_LIM : PERIOD_LIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_tmr   <= '0;
      rep_first <= 1'b1;
    end else if (!single) begin
      rep_tmr   <= '0;
      rep_first <= 1'b1;
    end else if (rise[2] || rise[1]) begin
      rep_tmr   <= 24'd1;
      rep_first <= 1'b1;
    end else if (rep_fire) begin
      rep_tmr   <= 24'd1;
      rep_first <= 1'b0;
    end else if (rep_tmr != 24'd0) begin
      rep_tmr   <= rep_tmr + 24'd1;
    end
  end

  assign rep_left  = rep_fire & deb[2];
  assign rep_right = rep_fire & deb[1];
`else
  assign rep_left  = 1'b0;
  assign rep_right = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q  <= 1'b0;
      right_q <= 1'b0;
      left_q  <= 1'b0;
    end else begin
      drop_q  <= rise[0];
      right_q <= (rise[1] & ~conflict) | rep_right;
      left_q  <= (rise[2] & ~conflict) | rep_left;
    end
  end

  assign bus.drop_pulse  = drop_q;
  assign bus.right_pulse = right_q;
  assign bus.left_pulse  = left_q;
  assign bus.btn_state   = deb;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized button
// activity, checked every cycle against a window-based behavioural model.
module tb_button_conditioner;
  localparam int DEB  = 4;
  localparam int RD   = 20;
  localparam int RP   = 8;
  localparam int HMAX = 4096;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  button_conditioner_if bus();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // model state: sampled inputs and debounced history since reset release
  bit   samp [3][HMAX];
  bit   debh [3][HMAX];
  int   last_flip [3];
  int   n;
  int   t0;
  int   side;
  int   cyc;
  int   scen_base;
  logic [5:0] exp_q[$];
  int   log_d[$];
  int   log_r[$];
  int   log_l[$];
  int   want[$];
  int   n_cmp;
  int   n_bad;

  function automatic bit sv(int b, int k);
    return (k >= 2) ? samp[b][k-2] : 1'b0;
  endfunction

  function automatic bit dh(int b, int k);
    return (k >= 0) ? debh[b][k] : 1'b0;
  endfunction

  // scoreboard: model one edge, queue its expectation, compare against DUT
  task automatic check_cycle();
    logic [5:0] act;
    logic [5:0] exp_v;
    logic [5:0] got_exp;
    bit [2:0] raw_v;
    bit [2:0] d1;
    bit [2:0] d2;
    bit [2:0] rs;
    bit pl, pr, pd, conf, prev, flip;
    int e;
    e = cyc - scen_base;
    if (rst) begin
      n  = 0;
      t0 = -1;
      for (int b = 0; b < 3; b++) last_flip[b] = -1;
      exp_v = '0;
    end else begin
      if (n >= HMAX) begin
        $display("FAIL model_capacity edge=%0d n=%0d limit=%0d", e, n, HMAX);
        $fatal(1, "model history exhausted");
      end
      raw_v = {bus.btn_left_in, bus.btn_right_in, bus.btn_drop_in};
      for (int b = 0; b < 3; b++) begin
        samp[b][n] = raw_v[b];
        prev = dh(b, n - 1);
        flip = (n - DEB >= last_flip[b] + 1);
        if (flip)
          for (int k = n - DEB; k <= n; k++)
            if (sv(b, k) == prev) flip = 1'b0;
        debh[b][n] = flip ? !prev : prev;
        if (flip) last_flip[b] = n;
      end
      d1   = {dh(2, n-1), dh(1, n-1), dh(0, n-1)};
      d2   = {dh(2, n-2), dh(1, n-2), dh(0, n-2)};
      rs   = d1 & ~d2;
      conf = d1[2] & d1[1];
      pd   = rs[0];
      pr   = rs[1] & !conf;
      pl   = rs[2] & !conf;
`ifdef AUTO_REPEAT_EN
      if (t0 >= 0) begin
        if (!(d1[side] && !d1[3-side])) t0 = -1;
        else if ((n - t0 >= RD) && ((n - t0 - RD) % RP == 0)) begin
          if (side == 2) pl = 1'b1;
          else pr = 1'b1;
        end
      end
      if (rs[2] && !conf) begin
        t0 = n; side = 2;
      end else if (rs[1] && !conf) begin
        t0 = n; side = 1;
      end
`endif
      exp_v = {dh(2, n), dh(1, n), dh(0, n), pl, pr, pd};
      if (pd) log_d.push_back(e);
      if (pr) log_r.push_back(e);
      if (pl) log_l.push_back(e);
      n++;
    end
    exp_q.push_back(exp_v);
    act     = {bus.btn_state, bus.left_pulse, bus.right_pulse, bus.drop_pulse};
    got_exp = exp_q.pop_front();
    n_cmp++;
    if (act !== got_exp) begin
      n_bad++;
      $display("FAIL cycle_check edge=%0d act{state,l,r,d}=%b exp=%b", e, act, got_exp);
    end
    cyc++;
  endtask

  // driver tasks
  task automatic tick(input logic [2:0] raw_v, input logic rst_v);
    @(negedge clk);
    rst = rst_v;
    {bus.btn_left_in, bus.btn_right_in, bus.btn_drop_in} = raw_v;
    @(posedge clk);
    #1;
    check_cycle();
  endtask

  task automatic hold(input logic [2:0] raw_v, input int cycles);
    for (int i = 0; i < cycles; i++) tick(raw_v, 1'b0);
  endtask

  task automatic start_scen();
    for (int i = 0; i < 3; i++) tick(3'b000, 1'b1);
    scen_base = cyc;
    log_d.delete();
    log_r.delete();
    log_l.delete();
  endtask

  task automatic check_log(input string name, input int got[$], input int exp_edges[$]);
    bit ok;
    ok = (got.size() == exp_edges.size());
    if (ok)
      for (int i = 0; i < got.size(); i++)
        if (got[i] != exp_edges[i]) ok = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s pulse_edges act=%p exp=%p", name, got, exp_edges);
    end
  endtask

  initial begin
    int div [3];
    {bus.btn_left_in, bus.btn_right_in, bus.btn_drop_in} = 3'b000;
    n = 0; t0 = -1; side = 1; cyc = 0; scen_base = 0; n_cmp = 0; n_bad = 0;
    for (int b = 0; b < 3; b++) last_flip[b] = -1;

    // clean right press
    start_scen();
    hold(3'b010, 20);
    hold(3'b000, 12);
    want.delete(); want.push_back(7);
    check_log("clean_right", log_r, want);
    want.delete();
    check_log("clean_left_quiet", log_l, want);
    check_log("clean_drop_quiet", log_d, want);

    // bounce on drop: 1,2,3-cycle pulses, then hold
    start_scen();
    tick(3'b001, 1'b0); tick(3'b000, 1'b0);
    tick(3'b001, 1'b0); tick(3'b001, 1'b0); tick(3'b000, 1'b0);
    tick(3'b001, 1'b0); tick(3'b001, 1'b0); tick(3'b001, 1'b0); tick(3'b000, 1'b0);
    hold(3'b001, 20);
    hold(3'b000, 12);
    want.delete(); want.push_back(16);
    check_log("bounce_drop", log_d, want);

    // left/right conflict, then right released
    start_scen();
    hold(3'b110, 40);
    hold(3'b100, 30);
    hold(3'b000, 12);
    want.delete();
    check_log("conflict_left", log_l, want);
    check_log("conflict_right", log_r, want);

    // long left hold
    start_scen();
    hold(3'b100, 60);
    hold(3'b000, 12);
    want.delete(); want.push_back(7);
`ifdef AUTO_REPEAT_EN
    want.push_back(27); want.push_back(35); want.push_back(43);
    want.push_back(51); want.push_back(59);
`endif
    check_log("repeat_left", log_l, want);

    // reset in the middle of a drop press, button held through release
    start_scen();
    hold(3'b001, 5);
    for (int i = 0; i < 5; i++) tick(3'b001, 1'b1);
    hold(3'b001, 20);
    hold(3'b000, 12);
    want.delete(); want.push_back(17);
    check_log("reset_drop", log_d, want);

    // drop and right together
    start_scen();
    hold(3'b011, 20);
    hold(3'b000, 12);
    want.delete(); want.push_back(7);
    check_log("indep_drop", log_d, want);
    check_log("indep_right", log_r, want);

    // randomized activity with occasional resets
    start_scen();
    begin
      logic [2:0] lv;
      lv = 3'b000;
      for (int blk = 0; blk < 15; blk++) begin
        for (int b = 0; b < 3; b++) begin
          case ($urandom_range(0, 2))
            0: div[b] = 3;
            1: div[b] = 15;
            default: div[b] = 60;
          endcase
        end
        for (int c = 0; c < 200; c++) begin
          for (int b = 0; b < 3; b++)
            if ($urandom_range(0, div[b] - 1) == 0) lv[b] = ~lv[b];
          if ($urandom_range(0, 599) == 0) begin
            for (int r = 0; r < int'($urandom_range(1, 3)); r++) tick(lv, 1'b1);
          end else begin
            tick(lv, 1'b0);
          end
        end
      end
    end
    hold(3'b000, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of consecutive cycles a synchronized level must hold before it is accepted (10 ms at 25 MHz); legal range 1..2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 10000000, is the hold time in cycles before the first auto-repeat pulse; legal range 2..2^24-1.
REQ-003 Parameter REPEAT_PERIOD, default 2500000, is the spacing in cycles between auto-repeat pulses; legal range 2..REPEAT_DELAY.
REQ-004 Port clk, input, 1, is the single clock (25 MHz pixel clock); all state SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1, is the asynchronous active-high reset.
REQ-006 Ports btn_drop_in, btn_right_in and btn_left_in, input, 1 each, are raw asynchronous push-button levels (1 = pressed).
REQ-007 Ports drop_pulse, right_pulse and left_pulse, output, 1 each, are single-cycle registered command strobes to the game controller.
REQ-008 Port btn_state, output, 3, SHALL carry the debounced levels {left, right, drop}.

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each button SHALL have an independent debounce counter: it increments while the synchronized level differs from the debounced level, and it clears to 0 in any cycle where the two levels are equal.
REQ-011 When a counter reaches DEBOUNCE_CYCLES, the debounced level SHALL take the synchronized level and the counter SHALL clear; glitches shorter than DEBOUNCE_CYCLES cycles SHALL cause no change.
REQ-012 A strobe SHALL assert for exactly 1 cycle, in the cycle after its debounced level rises 0->1.
REQ-013 Latency: with a clean input step, the strobe SHALL assert DEBOUNCE_CYCLES+3 rising edges after the first edge that samples the new level.
REQ-014 A debounced falling edge SHALL produce no strobe.
REQ-015 Left/right conflict: while both debounced left and debounced right are 1, neither left_pulse nor right_pulse SHALL assert, and this covers rises in the same cycle.
REQ-016 drop_pulse SHALL be independent of left and right, and SHALL never auto-repeat.
REQ-017 Outputs SHALL be driven directly from flops, with no combinational path from the inputs.

Reset
REQ-018 While rst is 1, the synchronizers, debounced levels, counters, btn_state and all strobes SHALL be 0, asynchronously.
REQ-019 A button held through reset release SHALL be treated as a new press: exactly one strobe at DEBOUNCE_CYCLES+3 edges after release.
REQ-020 Reset asserted mid-count or mid-repeat SHALL abort the count or repeat, and no strobe SHALL issue during reset.

Configuration
REQ-021 Macro AUTO_REPEAT_EN defined: while debounced left (or right) stays 1 with no conflict, a repeat strobe SHALL issue REPEAT_DELAY cycles after the initial strobe, then one every REPEAT_PERIOD cycles.
REQ-022 With AUTO_REPEAT_EN, the repeat timer SHALL restart on release, on a conflict condition and on reset; one shared 24-bit timer SHALL serve left and right.
REQ-023 Macro AUTO_REPEAT_EN undefined: there SHALL be exactly one strobe per debounced press, and no repeat timer logic SHALL be synthesized.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-024 Clean press: btn_right_in 0->1 sampled at edge 0 and held -> right_pulse high only at edge 7 and btn_state[1]=1 from edge 6.
REQ-025 Bounce: btn_drop_in toggles with 1-, 2- and 3-cycle pulses, then holds 1 -> exactly one drop_pulse, 7 edges after the final rise.
REQ-026 Conflict: btn_left_in and btn_right_in rise together and are held 40 cycles -> no left_pulse or right_pulse; release right -> no left strobe, since a strobe needs a rise.
REQ-027 Auto-repeat (macro defined): left held 60 cycles -> left_pulse at edges 7, 27, 35, 43, 51, 59; with the macro undefined -> edge 7 only.
REQ-028 Reset: rst asserted at edge 5 of a drop press and released at edge 10 with the button held -> no strobe during reset, one drop_pulse at edge 17.
REQ-029 Independence: drop and right pressed on the same edge -> drop_pulse and right_pulse both high at edge 7.
